// File: rtl/count_ctrl.sv
// count_ctrl: count game controller; debounced start/stop, START_NUM->0 countdown.
// Ports: clk, rst (async, active-low), btn_start, btn_stop -> num, st, done, running.
// Build macro COUNT_PAUSE_EN: stop in RUN pauses instead of aborting to IDLE.

module count_ctrl_deb #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);

  localparam int DW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
      evt <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      evt <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        // Level accepted; only a rising accepted level is an event.
        cnt <= '0;
        lvl <= s2;
        evt <= s2;
      end else begin
        cnt <= cnt + DEB_ONE;
      end
    end
  end

endmodule

module count_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int DEB_CYC   = 20,
  parameter int START_NUM = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  output logic [2:0] num,
  output logic       st,
  output logic       done,
  output logic       running
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    NUM_INIT  = 3'(START_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
`ifdef COUNT_PAUSE_EN
    ,
    S_PAUSE = 2'd3
`endif
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [2:0]    num_n;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_n;
  logic          done_n;
  logic          start_evt;
  logic          stop_evt;
  logic          go;

  count_ctrl_deb #(
    .DEB_CYC(DEB_CYC)
  ) u_deb_start (
    .clk(clk),
    .rst(rst),
    .raw(btn_start),
    .evt(start_evt)
  );

  count_ctrl_deb #(
    .DEB_CYC(DEB_CYC)
  ) u_deb_stop (
    .clk(clk),
    .rst(rst),
    .raw(btn_stop),
    .evt(stop_evt)
  );

  // Stop always beats a coincident start.
  assign go = start_evt & ~stop_evt;

  always_comb begin
    state_n = state;
    num_n   = num;
    tick_n  = tick;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        num_n  = NUM_INIT;
        tick_n = '0;
        if (go) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_evt) begin
`ifdef COUNT_PAUSE_EN
          state_n = S_PAUSE;
`else
          state_n = S_IDLE;
          num_n   = NUM_INIT;
          tick_n  = '0;
`endif
        end else if (tick != TICK_LAST) begin
          tick_n = tick + TICK_ONE;
        end else begin
          tick_n = '0;
          if (num != 3'd0) begin
            num_n = num - 3'd1;
          end
          if (num == 3'd1) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end
        end
      end
`ifdef COUNT_PAUSE_EN
      S_PAUSE: begin
        if (stop_evt) begin
          state_n = S_IDLE;
          num_n   = NUM_INIT;
          tick_n  = '0;
        end else if (start_evt) begin
          state_n = S_RUN;
        end
      end
`endif
      S_DONE: begin
        num_n  = 3'd0;
        tick_n = '0;
        if (stop_evt) begin
          state_n = S_IDLE;
          num_n   = NUM_INIT;
        end else if (start_evt) begin
          state_n = S_RUN;
          num_n   = NUM_INIT;
        end
      end
      default: begin
        state_n = S_IDLE;
        num_n   = NUM_INIT;
        tick_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      num     <= NUM_INIT;
      tick    <= '0;
      done    <= 1'b0;
      st      <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      num     <= num_n;
      tick    <= tick_n;
      done    <= done_n;
      st      <= (state_n != S_IDLE);
      running <= (state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: randomized self-checking bench for count_ctrl.
// Reference model tracks elapsed cycles and button sample history.

module tb_count_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int DEB_CYC   = 4;
  localparam int START_NUM = 7;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic [2:0] num;
  logic       st;
  logic       done;
  logic       running;

  int errors = 0;
  int checks = 0;

  int m_mode;
  int m_rem;
  int m_el;
  bit m_done;
  bit pz [2][2];
  bit lv [2];
  int sk [2];
  bit ev [2];

  count_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DEB_CYC  (DEB_CYC),
    .START_NUM(START_NUM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .num      (num),
    .st       (st),
    .done     (done),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_rem  = START_NUM;
    m_el   = 0;
    m_done = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pz[b][0] = 1'b0;
      pz[b][1] = 1'b0;
      lv[b]    = 1'b0;
      sk[b]    = 0;
      ev[b]    = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic rs, input logic rp);
    bit go;
    bit halt;
    bit raw [2];
    go     = ev[0] && !ev[1];
    halt   = ev[1];
    raw[0] = rs;
    raw[1] = rp;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (go) begin
          m_mode = M_RUN;
          m_rem  = START_NUM;
          m_el   = 0;
        end
      end
      M_RUN: begin
        if (halt) begin
`ifdef COUNT_PAUSE_EN
          m_mode = M_PAUSE;
`else
          m_mode = M_IDLE;
          m_rem  = START_NUM;
          m_el   = 0;
`endif
        end else begin
          m_el++;
          if (m_el == TICK_DIV) begin
            m_el = 0;
            m_rem--;
            if (m_rem == 0) begin
              m_mode = M_DONE;
              m_done = 1'b1;
            end
          end
        end
      end
      M_PAUSE: begin
        if (halt) begin
          m_mode = M_IDLE;
          m_rem  = START_NUM;
          m_el   = 0;
        end else if (go) begin
          m_mode = M_RUN;
        end
      end
      default: begin
        if (halt) begin
          m_mode = M_IDLE;
          m_rem  = START_NUM;
        end else if (go) begin
          m_mode = M_RUN;
          m_rem  = START_NUM;
          m_el   = 0;
        end
      end
    endcase
    for (int b = 0; b < 2; b++) begin
      ev[b] = 1'b0;
      if (pz[b][1] != lv[b]) begin
        sk[b]++;
        if (sk[b] == DEB_CYC) begin
          lv[b] = pz[b][1];
          ev[b] = pz[b][1];
          sk[b] = 0;
        end
      end else begin
        sk[b] = 0;
      end
      pz[b][1] = pz[b][0];
      pz[b][0] = raw[b];
    end
  endfunction

  function automatic logic [5:0] exp_out();
    logic [2:0] n;
    n = 3'(m_rem);
    return {n, m_mode != M_IDLE, m_mode == M_RUN, m_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_step(btn_start, btn_stop);
    @(negedge clk);
  endtask

  task automatic press(input logic s, input logic p, input int hold);
    btn_start = s;
    btn_stop  = p;
    repeat (hold) tick();
    btn_start = 1'b0;
    btn_stop  = 1'b0;
  endtask

  task automatic go_idle();
    for (int t = 0; t < 3 && m_mode != M_IDLE; t++) begin
      press(1'b0, 1'b1, 6);
      repeat (8) tick();
    end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({num, st, running, done} !== {3'd7, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b",
               {num, st, running, done}, {3'd7, 3'b000});
    end
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({num, st, running, done} !== {3'd7, 3'b000}) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, {3'd7, 3'b000});
      end
    end
  endtask

  task automatic test_run_full();
    int pulses = 0;
    int done_at = -1;
    int last = 0;
    int prev = START_NUM;
    int bad_step = 0;
    btn_start = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (i == 10) btn_start = 1'b0;
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL run_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
      if (i == 5) begin
        checks++;
        if (st !== 1'b0) begin
          errors++;
          $display("FAIL early_st got=%b want=0", st);
        end
      end
      if (i == 6) begin
        checks++;
        if (st !== 1'b1) begin
          errors++;
          $display("FAIL start_latency st got=%b want=1", st);
        end
        last = i;
      end
      if (done === 1'b1) begin
        pulses++;
        done_at = i;
      end
      if (i > 6 && int'(num) != prev) begin
        if (i - last != TICK_DIV || int'(num) != prev - 1) bad_step++;
        last = i;
        prev = int'(num);
      end
    end
    checks++;
    if (pulses != 1 || done_at != START_NUM * TICK_DIV + DEB_CYC + 2) begin
      errors++;
      $display("FAIL done_pulse got count=%0d at=%0d want count=1 at=%0d",
               pulses, done_at, START_NUM * TICK_DIV + DEB_CYC + 2);
    end
    checks++;
    if (bad_step != 0 || prev != 0) begin
      errors++;
      $display("FAIL step_cadence got bad=%0d last_num=%0d want bad=0 last_num=0",
               bad_step, prev);
    end
    checks++;
    if ({num, st, running} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL end_state got=%b want=%b",
               {num, st, running}, {3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_bounce();
    int per;
    go_idle();
    per = $urandom_range(1, 3);
    for (int i = 0; i < 30; i++) begin
      btn_start = (i < 12) ? 1'(((i / per) % 2) == 0) : 1'b0;
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
    end
    checks++;
    if ({num, st} !== {3'd7, 1'b0}) begin
      errors++;
      $display("FAIL bounce_no_event period=%0d got=%b want=%b",
               per, {num, st}, {3'd7, 1'b0});
    end
  endtask

  task automatic test_stop_mid();
    int waited = 0;
    int pulses = 0;
    go_idle();
    press(1'b1, 1'b0, 6);
    while (!(m_mode == M_RUN && m_rem == 4 && m_el == 0) && waited < 200) begin
      tick();
      waited++;
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL stop_wait cyc=%0d got=%b want=%b",
                 waited, {num, st, running, done}, exp_out());
      end
    end
    checks++;
    if (waited >= 200) begin
      errors++;
      $display("FAIL stop_reach4 timeout got num=%0d want 4", num);
    end
    btn_stop = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    for (int i = 0; i < 56; i++) begin
      btn_stop = (i < 6);
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL stop_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
    end
    checks++;
`ifdef COUNT_PAUSE_EN
    if ({num, st, running} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pause_freeze got=%b want=%b",
               {num, st, running}, {3'd4, 1'b1, 1'b0});
    end
    btn_start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 6) btn_start = 1'b0;
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL resume_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || num !== 3'd0) begin
      errors++;
      $display("FAIL resume_done got pulses=%0d num=%0d want 1 and 0",
               pulses, num);
    end
`else
    if ({num, st, running} !== {3'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_abort got=%b want=%b",
               {num, st, running}, {3'd7, 1'b0, 1'b0});
    end
`endif
  endtask

  task automatic test_simul();
    go_idle();
    for (int i = 0; i < 20; i++) begin
      btn_start = (i < 6);
      btn_stop  = (i < 6);
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL simul_idle_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
    end
    checks++;
    if ({num, st} !== {3'd7, 1'b0}) begin
      errors++;
      $display("FAIL simul_idle got=%b want=%b", {num, st}, {3'd7, 1'b0});
    end
    press(1'b1, 1'b0, 6);
    repeat ($urandom_range(4, 8)) tick();
    for (int i = 0; i < 20; i++) begin
      btn_start = (i < 6);
      btn_stop  = (i < 6);
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL simul_run_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
    end
    checks++;
`ifdef COUNT_PAUSE_EN
    if ({st, running} !== 2'b10) begin
      errors++;
      $display("FAIL simul_run got st,run=%b want=10", {st, running});
    end
`else
    if ({num, st, running} !== {3'd7, 2'b00}) begin
      errors++;
      $display("FAIL simul_run got=%b want=%b",
               {num, st, running}, {3'd7, 2'b00});
    end
`endif
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int pulses = 0;
    go_idle();
    press(1'b1, 1'b0, 6);
    while (m_rem != 3 && waited < 200) begin
      tick();
      waited++;
    end
    checks++;
    if (num !== 3'd3) begin
      errors++;
      $display("FAIL rst_reach3 got num=%0d want 3", num);
    end
    btn_start = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({num, st, running, done} !== {3'd7, 3'b000}) begin
      errors++;
      $display("FAIL rst_async got=%b want=%b",
               {num, st, running, done}, {3'd7, 3'b000});
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 8) btn_start = 1'b0;
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL rst_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
      if (done === 1'b1) pulses++;
      if (i == 6) begin
        checks++;
        if ({num, running} !== {3'd7, 1'b1}) begin
          errors++;
          $display("FAIL held_through_rst got=%b want=%b",
                   {num, running}, {3'd7, 1'b1});
        end
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_no_done got pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    int hs = 0;
    int hp = 0;
    go_idle();
    for (int i = 0; i < 600; i++) begin
      if (hs == 0) begin
        btn_start = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 14);
      end else begin
        hs--;
      end
      if (hp == 0) begin
        btn_stop = ($urandom_range(0, 3) == 0);
        hp = $urandom_range(1, 14);
      end else begin
        hp--;
      end
      tick();
      checks++;
      if ({num, st, running, done} !== exp_out()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%b want=%b",
                 i, {num, st, running, done}, exp_out());
      end
    end
    btn_start = 1'b0;
    btn_stop  = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_full();
    test_bounce();
    test_stop_mid();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
